uart_receiver: RTL and testbench

UART receive path, the counterpart of the transmitter: deserialises the RX line into bytes using a 16x oversampling tick from the baud rate generator. Provides a 32-bit holding register and a 32-bit status word in the same register style as the transmit side. Sits between the external RX pin and the host register interface.

---
 rtl/uart_receiver.sv | 207 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : 16x-oversampled UART receive path. Synchronises the RX pin,
//            hunts for a start bit, samples data/parity/stop at bit centres
//            and presents the byte plus sticky status flags in 32-bit
//            host-facing registers.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int DATA_BITS  = 8,  // 5..8 data bits, LSB first
  parameter int PARITY_EN  = 0,  // 1 = parity bit follows the data bits
  parameter int PARITY_ODD = 0   // 1 = odd parity, 0 = even
) (
  input  logic        clk,
  input  logic        rst,                        // synchronous, active-low
  input  logic        sample_tick,                // 16x baud strobe
  input  logic        RX,                         // asynchronous serial line
  input  logic        Receiver_Read,              // host consumed the data
  output logic [31:0] Receiver_Holding_Register,
  output logic [31:0] Receiver_Status
);

  // Bit-counter width: enough to index every data bit.
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);
  localparam bit ODD_BIT   = (PARITY_ODD != 0);
  localparam bit HAS_PAR   = (PARITY_EN != 0);

  // Receiver state encoding. DONE is the single-clock completion slot that
  // follows the stop-bit sample.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd6;

  // Synchroniser
  logic rx_meta_q, rx_meta_d;
  logic rxs_q, rxs_d;

  // Frame sequencing
  logic [2:0]           state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_pend_q, par_pend_d;
  logic                 stop_bit_q, stop_bit_d;

  // Host-visible registers
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 data_ready_q, data_ready_d;
  logic                 overrun_q, overrun_d;
  logic                 parity_error_q, parity_error_d;
  logic                 framing_error_q, framing_error_d;

  // Decoded sampling points
  logic mid_tick;   // centre of the start bit
  logic end_tick;   // centre of data/parity/stop bits (one full bit later)
  logic last_bit;
  logic complete;
  logic busy;

  assign mid_tick = sample_tick && (tick_cnt_q == 4'd7);
  assign end_tick = sample_tick && (tick_cnt_q == 4'd15);
  assign last_bit = (bit_cnt_q == LAST_BIT);
  assign complete = (state_q == ST_DONE);

  // State register and all datapath flops; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q       <= 1'b1;
      rxs_q           <= 1'b1;
      state_q         <= ST_IDLE;
      tick_cnt_q      <= 4'd0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      par_pend_q      <= 1'b0;
      stop_bit_q      <= 1'b1;
      hold_q          <= '0;
      data_ready_q    <= 1'b0;
      overrun_q       <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      rx_meta_q       <= rx_meta_d;
      rxs_q           <= rxs_d;
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      par_pend_q      <= par_pend_d;
      stop_bit_q      <= stop_bit_d;
      hold_q          <= hold_d;
      data_ready_q    <= data_ready_d;
      overrun_q       <= overrun_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
    end
  end

  // Next-state logic: walk start / data / [parity] / stop at bit centres.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rxs_q) state_d = ST_START;
      end
      ST_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (mid_tick) state_d = rxs_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (end_tick && last_bit) state_d = HAS_PAR ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (end_tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (end_tick) state_d = ST_DONE;
      end
      ST_DONE: begin
        // A low stop bit means a break or a held-low line: wait it out.
        state_d = stop_bit_q ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (rxs_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: synchroniser, oversampling counters, shift register, flags.
  always_comb begin
    rx_meta_d       = RX;
    rxs_d           = rx_meta_q;
    tick_cnt_d      = tick_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    par_pend_d      = par_pend_q;
    stop_bit_d      = stop_bit_q;
    hold_d          = hold_q;
    data_ready_d    = data_ready_q;
    overrun_d       = overrun_q;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;

    // Tick counter free-runs on the oversampling strobe, wrapping 15->0.
    if (sample_tick) tick_cnt_d = tick_cnt_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        // Held at zero so the start-bit search begins from a known phase.
        tick_cnt_d = 4'd0;
        bit_cnt_d  = '0;
      end
      ST_START: begin
        if (mid_tick && !rxs_q) begin
          tick_cnt_d = 4'd0;
          bit_cnt_d  = '0;
          par_pend_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (end_tick) begin
          shift_d[bit_cnt_q] = rxs_q;
          bit_cnt_d          = bit_cnt_q + BIT_ONE;
        end
      end
      ST_PARITY: begin
        if (end_tick) par_pend_d = rxs_q ^ (^shift_q) ^ ODD_BIT;
      end
      ST_STOP: begin
        if (end_tick) stop_bit_d = rxs_q;
      end
      default: ;
    endcase

    // Completion outranks a coincident host read: the fresh frame stays
    // visible, and the read only suppresses the overrun it would have caused.
    if (complete) begin
      hold_d          = shift_q;
      data_ready_d    = 1'b1;
      overrun_d       = Receiver_Read ? 1'b0 : (overrun_q | data_ready_q);
      parity_error_d  = par_pend_q;
      framing_error_d = !stop_bit_q;
    end else if (Receiver_Read) begin
      data_ready_d    = 1'b0;
      overrun_d       = 1'b0;
      parity_error_d  = 1'b0;
      framing_error_d = 1'b0;
    end
  end

  // Output decode: pack holding data and status into 32-bit registers.
  always_comb begin
    busy                      = (state_q != ST_IDLE);
    Receiver_Holding_Register = {{(32 - DATA_BITS){1'b0}}, hold_q};
    Receiver_Status           = {27'd0, busy, framing_error_q, parity_error_q,
                                 overrun_q, data_ready_q};
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Self-checking bench for uart_receiver. Drives one 8N1 and one
//            8E1 instance with directed and random frames and compares the
//            host registers against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  tick_div = 2'd0;
  logic        sample_tick;
  logic        rx_a, rx_p, rd_a, rd_p;
  logic [31:0] hold_a, stat_a, hold_p, stat_p;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state per instance (0 = 8N1, 1 = 8E1)
  logic [7:0] m_hold  [2];
  bit         m_ready [2];
  bit         m_ovr   [2];
  bit         m_par   [2];
  bit         m_frm   [2];

  always #5 clk = ~clk;

  // 16x strobe every 4 clocks: one bit lasts 64 clocks.
  always @(posedge clk) tick_div <= tick_div + 2'd1;
  assign sample_tick = (tick_div == 2'd3);

  uart_receiver #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .sample_tick               (sample_tick),
    .RX                        (rx_a),
    .Receiver_Read             (rd_a),
    .Receiver_Holding_Register (hold_a),
    .Receiver_Status           (stat_a)
  );

  uart_receiver #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk                       (clk),
    .rst                       (rst),
    .sample_tick               (sample_tick),
    .RX                        (rx_p),
    .Receiver_Read             (rd_p),
    .Receiver_Holding_Register (hold_p),
    .Receiver_Status           (stat_p)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_of(input int d);
    return (d == 0) ? stat_a : stat_p;
  endfunction

  function automatic logic [31:0] hold_of(input int d);
    return (d == 0) ? hold_a : hold_p;
  endfunction

  function automatic logic [31:0] exp_stat(input int d, input bit busy);
    return {27'd0, busy, m_frm[d], m_par[d], m_ovr[d], m_ready[d]};
  endfunction

  task automatic check_dut(input int d, input string tag, input bit busy);
    check({tag, "_status"}, stat_of(d), exp_stat(d, busy));
    check({tag, "_hold"}, hold_of(d), {24'd0, m_hold[d]});
  endtask

  // Model: a completed frame with the given content.
  task automatic m_complete(input int d, input logic [7:0] data, input bit perr,
                            input bit ferr, input bit rd);
    m_ovr[d]   = rd ? 1'b0 : (m_ovr[d] | m_ready[d]);
    m_ready[d] = 1'b1;
    m_par[d]   = perr;
    m_frm[d]   = ferr;
    m_hold[d]  = data;
  endtask

  task automatic m_read(input int d);
    m_ready[d] = 1'b0;
    m_ovr[d]   = 1'b0;
    m_par[d]   = 1'b0;
    m_frm[d]   = 1'b0;
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_read(d);
      m_hold[d] = 8'd0;
    end
  endtask

  task automatic drive_rx(input int d, input logic v);
    if (d == 0) rx_a = v; else rx_p = v;
  endtask

  task automatic drive_rd(input int d, input logic v);
    if (d == 0) rd_a = v; else rd_p = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic host_read(input int d);
    drive_rd(d, 1'b1);
    @(negedge clk);
    drive_rd(d, 1'b0);
    m_read(d);
  endtask

  // Send one frame, started on a negedge where the strobe is high so the
  // completion clock is known: the stop bit is the T-th counted tick after
  // the start bit is seen (T = 8 + 16*(bits after start)), which lands on
  // clock edge 1+4T and completes on the edge after it.
  task automatic send_frame(input int d, input logic [7:0] data, input bit par_bit,
                            input bit stop, input bit rd_coinc);
    logic [10:0] bits;
    int nb;
    int rd_at;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (d == 0) begin
      bits[9] = stop;
      nb      = 10;
    end else begin
      bits[9]  = par_bit;
      bits[10] = stop;
      nb       = 11;
    end
    rd_at = 1 + 4 * (8 + 16 * (nb - 1));
    while (sample_tick !== 1'b1) @(negedge clk);
    for (int c = 0; c < nb * 64; c++) begin
      drive_rx(d, bits[c / 64]);
      drive_rd(d, rd_coinc && (c == rd_at));
      if (c == 300) check("busy_mid_frame", {31'd0, stat_of(d)[4]}, 32'd1);
      @(negedge clk);
    end
    drive_rd(d, 1'b0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [7:0] data;
    bit         stop, par_bit, rd_c, perr;
    int         d;

    // Reset held for 3 clocks while RX toggles
    rst  = 1'b0;
    rx_a = 1'b0; rx_p = 1'b1;
    rd_a = 1'b0; rd_p = 1'b0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_a = ~rx_a;
      rx_p = ~rx_p;
    end
    check_dut(0, "reset_a", 1'b0);
    check_dut(1, "reset_p", 1'b0);
    rx_a = 1'b1; rx_p = 1'b1;
    rst  = 1'b1;
    idle(20);
    check_dut(0, "post_reset_idle", 1'b0);

    // Clean 8N1 frame
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
    m_complete(0, 8'hA5, 1'b0, 1'b0, 1'b0);
    check_dut(0, "clean_A5", 1'b0);
    host_read(0);
    check_dut(0, "clean_read", 1'b0);

    // False start: low for 20 clocks only
    rx_a = 1'b0;
    idle(20);
    rx_a = 1'b1;
    idle(60);
    check_dut(0, "false_start", 1'b0);

    // Framing error then line held low for five bit times
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    m_complete(0, 8'h3C, 1'b0, 1'b1, 1'b0);
    idle(5 * 64);
    check_dut(0, "break_low", 1'b1);
    rx_a = 1'b1;
    idle(20);
    check_dut(0, "break_released", 1'b0);
    host_read(0);

    // Overrun
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0);
    m_complete(0, 8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0);
    m_complete(0, 8'h22, 1'b0, 1'b0, 1'b0);
    check_dut(0, "overrun", 1'b0);
    host_read(0);
    check_dut(0, "overrun_read", 1'b0);

    // Read coincident with completion
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0);
    m_complete(0, 8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
    m_complete(0, 8'h22, 1'b0, 1'b0, 1'b1);
    check_dut(0, "coincident_read", 1'b0);
    host_read(0);

    // Even parity instance
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
    m_complete(1, 8'h07, 1'b0, 1'b0, 1'b0);
    check_dut(1, "parity_ok", 1'b0);
    host_read(1);
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0);
    m_complete(1, 8'h07, 1'b1, 1'b0, 1'b0);
    check_dut(1, "parity_bad", 1'b0);
    host_read(1);
    check_dut(1, "parity_read", 1'b0);

    // Reset in the middle of a frame with data already pending
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0);
    m_complete(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    rx_a = 1'b0;
    idle(100);
    rst  = 1'b0;
    rx_a = 1'b1;
    idle(2);
    rst = 1'b1;
    m_reset();
    idle(20);
    check_dut(0, "midframe_reset_a", 1'b0);
    check_dut(1, "midframe_reset_p", 1'b0);

    // Random frames against the model
    for (int it = 0; it < 14; it++) begin
      d       = int'($urandom_range(1, 0));
      data    = 8'($urandom);
      stop    = ($urandom_range(3, 0) != 0);
      par_bit = 1'($urandom);
      rd_c    = ($urandom_range(3, 0) == 0);
      perr    = (d == 1) && (par_bit != ($countones(data) % 2 == 1));
      send_frame(d, data, par_bit, stop, rd_c);
      m_complete(d, data, perr, !stop, rd_c);
      if (!stop) begin
        idle(64 * $urandom_range(2, 0));
        check_dut(d, "rand_break", 1'b1);
        drive_rx(d, 1'b1);
      end
      idle(32);
      check_dut(d, "rand_frame", 1'b0);
      if ($urandom_range(1, 0) == 1) begin
        host_read(d);
        check_dut(d, "rand_read", 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
